twiddle_sequencer: RTL and testbench

Parametrised twiddle-factor source for an N-point radix-2 DIT FFT (N = 2^LOG2N). On a start pulse it streams, stage by stage and butterfly by butterfly, the twiddle W_N^k required by each butterfly, together with stage/index tags, over a valid/ready handshake. It replaces the fixed 16-point combinational twiddle table as the coefficient feed for the butterfly datapath.

---
 rtl/twiddle_pkg.sv | 30 +++
 rtl/twiddle_rom.sv | 56 +++++
 rtl/twiddle_sequencer.sv | 146 ++++++++++++++
 tb/tb_twiddle_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_pkg.sv
// Shared types and elaboration-time helpers for the twiddle-factor sequencer.
// Twiddle values are rounded half away from zero onto a Q1.(WIDTH-1) grid.
package twiddle_pkg;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam int unsigned DefLog2n = 4;
  localparam int unsigned N        = 1 << DefLog2n;
  localparam int unsigned NHalf    = N / 2;

  localparam real Pi = 3.14159265358979323846;

  // +1.0 maps to 2^(width-1)-1 so that the positive full scale stays representable.
  function automatic int q_round(real x, int unsigned width);
    real scaled;
    scaled = x * $itor((1 << (width - 1)) - 1);
    if (scaled >= 0.0) return $rtoi(scaled + 0.5);
    return -$rtoi(0.5 - scaled);
  endfunction

  // One table entry: real part cos(2*pi*k/N), imaginary part -sin(2*pi*k/N).
  function automatic int twiddle_entry(int unsigned k, int unsigned log2n, int unsigned width,
                                       bit imag);
    real ang;
    ang = 2.0 * Pi * $itor(k) / $itor(1 << log2n);
    if (imag) return q_round(-$sin(ang), width);
    return q_round($cos(ang), width);
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Combinational twiddle lookup k -> (wr, wi), tables built at elaboration time.
// TWIDDLE_QUARTER_ROM_EN selects a quarter-wave cosine table; outputs are identical.
module twiddle_rom
  import twiddle_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LOG2N = 4
) (
  input  logic [LOG2N-2:0] k,
  output logic [WIDTH-1:0] wr,
  output logic [WIDTH-1:0] wi
);

`ifdef TWIDDLE_QUARTER_ROM_EN
  localparam int unsigned NQuarter = (1 << LOG2N) / 4;

  logic signed [WIDTH-1:0] cos_tab [NQuarter+1];

  for (genvar i = 0; i <= NQuarter; i++) begin : g_cos
    localparam int C = twiddle_entry(i, LOG2N, WIDTH, 1'b0);
    assign cos_tab[i] = WIDTH'(C);
  end

  logic [LOG2N-2:0] r_idx;
  logic [LOG2N-2:0] mirror_idx;

  // k < N/2, so the top bit of k alone says whether k falls in the second quadrant.
  always_comb begin
    r_idx      = {1'b0, k[LOG2N-3:0]};
    mirror_idx = (LOG2N-1)'(NQuarter) - r_idx;
    if (!k[LOG2N-2]) begin
      wr = cos_tab[r_idx];
      wi = -cos_tab[mirror_idx];
    end else begin
      wr = -cos_tab[mirror_idx];
      wi = -cos_tab[r_idx];
    end
  end
`else
  localparam int unsigned NHalfPts = (1 << LOG2N) / 2;

  logic [WIDTH-1:0] wr_tab [NHalfPts];
  logic [WIDTH-1:0] wi_tab [NHalfPts];

  for (genvar i = 0; i < NHalfPts; i++) begin : g_full
    localparam int Wr = twiddle_entry(i, LOG2N, WIDTH, 1'b0);
    localparam int Wi = twiddle_entry(i, LOG2N, WIDTH, 1'b1);
    assign wr_tab[i] = WIDTH'(Wr);
    assign wi_tab[i] = WIDTH'(Wi);
  end

  assign wr = wr_tab[k];
  assign wi = wi_tab[k];
`endif

endmodule

// File: rtl/twiddle_sequencer.sv
// Streams the twiddle for every butterfly of an N-point radix-2 DIT FFT, stage by stage.
// Build option TWIDDLE_QUARTER_ROM_EN (inside twiddle_rom) picks the quarter-wave table.
module twiddle_sequencer
  import twiddle_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LOG2N = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_wr,
  output logic [WIDTH-1:0]         out_wi,
  output logic [LOG2N-2:0]         out_k,
  output logic [$clog2(LOG2N)-1:0] out_stage,
  output logic [LOG2N-2:0]         out_idx,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned NPts  = 1 << LOG2N;
  localparam int unsigned NHlf  = NPts / 2;
  localparam int unsigned KW    = LOG2N - 1;
  localparam int unsigned SW    = $clog2(LOG2N);

  state_e state_q, state_d;

  logic             valid_q, last_q, done_q;
  logic [WIDTH-1:0] wr_q, wi_q;
  logic [KW-1:0]    k_q, idx_q;
  logic [SW-1:0]    stage_q;

  logic             accept, cur_last, load, clear, done_d, last_d;
  logic [SW-1:0]    stage_d;
  logic [KW-1:0]    idx_d, k_d, idx_mask;
  logic [WIDTH-1:0] rom_wr, rom_wi;

  // In RUN the register always holds a valid word, so acceptance is the only load trigger.
  assign accept   = valid_q & out_ready;
  assign cur_last = (stage_q == SW'(LOG2N - 1)) && (idx_q == KW'(NHlf - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun:  if (accept && cur_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    clear   = 1'b0;
    done_d  = 1'b0;
    stage_d = stage_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          stage_d = '0;
          idx_d   = '0;
        end
      end
      StRun: begin
        if (accept) begin
          if (cur_last) begin
            clear  = 1'b1;
            done_d = 1'b1;
          end else begin
            load = 1'b1;
            if (idx_q == KW'(NHlf - 1)) begin
              idx_d   = '0;
              stage_d = stage_q + SW'(1);
            end else begin
              idx_d = idx_q + KW'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  // k = (b mod 2^s) << (LOG2N-1-s)
  always_comb begin
    idx_mask = KW'((32'd1 << stage_d) - 32'd1);
    k_d      = (idx_d & idx_mask) << (KW - 32'(stage_d));
    last_d   = (stage_d == SW'(LOG2N - 1)) && (idx_d == KW'(NHlf - 1));
  end

  twiddle_rom #(
    .WIDTH(WIDTH),
    .LOG2N(LOG2N)
  ) u_rom (
    .k (k_d),
    .wr(rom_wr),
    .wi(rom_wi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= '0;
      wi_q    <= '0;
      k_q     <= '0;
      stage_q <= '0;
      idx_q   <= '0;
    end else begin
      done_q <= done_d;
      if (load) begin
        valid_q <= 1'b1;
        last_q  <= last_d;
        wr_q    <= rom_wr;
        wi_q    <= rom_wi;
        k_q     <= k_d;
        stage_q <= stage_d;
        idx_q   <= idx_d;
      end else if (clear) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_wr    = wr_q;
  assign out_wi    = wi_q;
  assign out_k     = k_q;
  assign out_stage = stage_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign busy      = (state_q == StRun);
  assign done      = done_q;

endmodule

// File: tb/tb_twiddle_sequencer.sv
// Directed bench for twiddle_sequencer: N=16 instance plus an N=64 instance for the larger table.
module tb_twiddle_sequencer;

  logic        clk, rst;
  logic        start, out_ready, out_valid, out_last, busy, done;
  logic [15:0] out_wr, out_wi;
  logic [2:0]  out_k, out_idx;
  logic [1:0]  out_stage;

  logic        start6, ready6, valid6, last6, busy6, done6;
  logic [15:0] wr6, wi6;
  logic [4:0]  k6, idx6;
  logic [2:0]  stage6;

  int n_checks = 0;
  int n_pass   = 0;

  twiddle_sequencer #(.WIDTH(16), .LOG2N(4)) dut (
    .clk(clk), .rst(rst), .start(start), .out_valid(out_valid), .out_ready(out_ready),
    .out_wr(out_wr), .out_wi(out_wi), .out_k(out_k), .out_stage(out_stage),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
  );

  twiddle_sequencer #(.WIDTH(16), .LOG2N(6)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .out_valid(valid6), .out_ready(ready6),
    .out_wr(wr6), .out_wi(wi6), .out_k(k6), .out_stage(stage6),
    .out_idx(idx6), .out_last(last6), .busy(busy6), .done(done6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [64:0] pack_word(int s, int b, int k, int wr, int wi, logic last);
    return {8'(s), 12'(b), 12'(k), 16'(wr), 16'(wi), last};
  endfunction

  function automatic int m_round(real x);
    real v;
    v = x * 32767.0;
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  // Reference word number n of the stream for an N = 2^log2n transform.
  function automatic logic [64:0] model_word(int n, int log2n);
    int  half, s, b, k;
    real ang;
    half = (1 << log2n) / 2;
    s    = n / half;
    b    = n % half;
    k    = (b % (1 << s)) << (log2n - 1 - s);
    ang  = 2.0 * 3.14159265358979323846 * $itor(k) / $itor(1 << log2n);
    return pack_word(s, b, k, m_round($cos(ang)), m_round(-$sin(ang)),
                     n == log2n * half - 1);
  endfunction

  function automatic logic [64:0] dut_word();
    return pack_word(int'(out_stage), int'(out_idx), int'(out_k), int'($signed(out_wr)),
                     int'($signed(out_wi)), out_last);
  endfunction

  function automatic logic [64:0] dut6_word();
    return pack_word(int'(stage6), int'(idx6), int'(k6), int'($signed(wr6)),
                     int'($signed(wi6)), last6);
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; start6 = 1'b0; ready6 = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, busy, done} !== 3'b000)
      $display("FAIL reset_ctrl: got valid/busy/done=%b want 000", {out_valid, busy, done});
    else n_pass++;
    n_checks++;
    if (dut_word() !== 65'd0) $display("FAIL reset_data: got %h want 0", dut_word());
    else n_pass++;
    n_checks++;
    if ({valid6, busy6, done6} !== 3'b000)
      $display("FAIL reset_ctrl6: got %b want 000", {valid6, busy6, done6});
    else n_pass++;
  endtask

  task automatic test_full_run();
    int n = 0;
    int cyc = 0;
    logic [31:0] pair;
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if (!(out_valid === 1'b1 && out_stage === 2'd0 && out_idx === 3'd0 && busy === 1'b1))
      $display("FAIL first_latency: got valid=%b s=%0d b=%0d busy=%b want 1 0 0 1",
               out_valid, out_stage, out_idx, busy);
    else n_pass++;
    while (n < 32 && cyc < 100) begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (dut_word() !== model_word(n, 4))
          $display("FAIL full_word%0d: got %h want %h", n, dut_word(), model_word(n, 4));
        else n_pass++;
        pair = {out_wr, out_wi};
        if (n < 8) begin
          n_checks++;
          if (pair !== {16'sd32767, 16'sd0})
            $display("FAIL stage0_word%0d: got %h want 7fff0000", n, pair);
          else n_pass++;
        end
        if (n == 26) begin
          n_checks++;
          if (pair !== {16'sd23170, -16'sd23170})
            $display("FAIL s3_b2: got %h want 5a82a57e", pair);
          else n_pass++;
        end
        if (n == 28) begin
          n_checks++;
          if (pair !== {16'sd0, -16'sd32767}) $display("FAIL s3_b4: got %h want 00008001", pair);
          else n_pass++;
        end
        if (n == 30) begin
          n_checks++;
          if (pair !== {-16'sd23170, -16'sd23170})
            $display("FAIL s3_b6: got %h want a57ea57e", pair);
          else n_pass++;
        end
        n++;
      end
      tick(); cyc++;
    end
    n_checks++;
    if (n !== 32) $display("FAIL full_count: got %0d want 32", n);
    else n_pass++;
    n_checks++;
    if ({done, out_valid, busy} !== 3'b100)
      $display("FAIL full_done: got done/valid/busy=%b want 100", {done, out_valid, busy});
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0) $display("FAIL done_pulse_width: got %b want 0", done);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int n = 0;
    int cyc = 0;
    logic [64:0] held;
    start = 1'b1; tick(); start = 1'b0;
    while (n < 32 && cyc < 100) begin
      if (n == 11 && out_ready) begin
        out_ready = 1'b0;
        held = dut_word();
        n_checks++;
        if (held !== pack_word(1, 3, 4, 0, -32767, 1'b0))
          $display("FAIL stall_word: got %h want %h", held, pack_word(1, 3, 4, 0, -32767, 1'b0));
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
          tick(); cyc++;
          n_checks++;
          if (out_valid !== 1'b1 || dut_word() !== held)
            $display("FAIL stall_hold%0d: got valid=%b %h want 1 %h", i, out_valid, dut_word(),
                     held);
          else n_pass++;
        end
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (dut_word() !== model_word(n, 4))
          $display("FAIL bp_word%0d: got %h want %h", n, dut_word(), model_word(n, 4));
        else n_pass++;
        n++;
      end
      tick(); cyc++;
    end
    n_checks++;
    if (n !== 32 || done !== 1'b1) $display("FAIL bp_count: got %0d done=%b want 32 1", n, done);
    else n_pass++;
    tick();
  endtask

  task automatic test_start_rst();
    int n = 0;
    int cyc = 0;
    start = 1'b1; tick(); start = 1'b0;
    while (n < 32 && cyc < 100) begin
      start = 1'b0;
      if (out_valid && out_ready) begin
        n_checks++;
        if (dut_word() !== model_word(n, 4))
          $display("FAIL busy_start_word%0d: got %h want %h", n, dut_word(), model_word(n, 4));
        else n_pass++;
        if (n == 5 || n == 20) start = 1'b1;
        n++;
      end
      tick(); cyc++;
    end
    start = 1'b0;
    n_checks++;
    if (n !== 32 || done !== 1'b1)
      $display("FAIL busy_start_count: got %0d done=%b want 32 1", n, done);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL busy_start_idle: got valid=%b busy=%b want 0 0", out_valid, busy);
    else n_pass++;

    n = 0; cyc = 0;
    start = 1'b1; tick(); start = 1'b0;
    while (n < 10 && cyc < 50) begin
      if (out_valid && out_ready) n++;
      tick(); cyc++;
    end
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++;
    if ({out_valid, busy, done} !== 3'b000 || dut_word() !== 65'd0)
      $display("FAIL abort_state: got ctrl=%b data=%h want 000 0", {out_valid, busy, done},
               dut_word());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL abort_quiet%0d: got done=%b valid=%b want 0 0", i, done, out_valid);
      else n_pass++;
    end
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || dut_word() !== model_word(0, 4))
      $display("FAIL restart_first: got valid=%b %h want 1 %h", out_valid, dut_word(),
               model_word(0, 4));
    else n_pass++;
    n = 0; cyc = 0;
    while (n < 32 && cyc < 100) begin
      if (out_valid && out_ready) n++;
      tick(); cyc++;
    end
    n_checks++;
    if (n !== 32 || done !== 1'b1) $display("FAIL restart_count: got %0d want 32", n);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int cyc = 0;
    start = 1'b1; tick(); start = 1'b0;
    while (n < 32 && cyc < 100) begin
      if (out_valid && out_ready) n++;
      tick(); cyc++;
    end
    n_checks++;
    if (done !== 1'b1) $display("FAIL b2b_done: got %b want 1", done);
    else n_pass++;
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || dut_word() !== model_word(0, 4))
      $display("FAIL b2b_first: got valid=%b busy=%b %h want 1 1 %h", out_valid, busy,
               dut_word(), model_word(0, 4));
    else n_pass++;
    n = 0; cyc = 0;
    while (n < 32 && cyc < 100) begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (dut_word() !== model_word(n, 4))
          $display("FAIL b2b_word%0d: got %h want %h", n, dut_word(), model_word(n, 4));
        else n_pass++;
        n++;
      end
      tick(); cyc++;
    end
    n_checks++;
    if (n !== 32 || done !== 1'b1) $display("FAIL b2b_count: got %0d done=%b want 32 1", n, done);
    else n_pass++;
    tick();
  endtask

  task automatic test_log2n6();
    int n = 0;
    int cyc = 0;
    start6 = 1'b1; tick(); start6 = 1'b0;
    while (n < 192 && cyc < 400) begin
      if (valid6 && ready6) begin
        n_checks++;
        if (dut6_word() !== model_word(n, 6))
          $display("FAIL n64_word%0d: got %h want %h", n, dut6_word(), model_word(n, 6));
        else n_pass++;
        n++;
      end
      tick(); cyc++;
    end
    n_checks++;
    if (n !== 192 || done6 !== 1'b1)
      $display("FAIL n64_count: got %0d done=%b want 192 1", n, done6);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_backpressure();
    test_start_rst();
    test_back_to_back();
    test_log2n6();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
